// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_pkg
//  Description : Shared defaults, clear-sequencer state encoding and index
//                width helper for the self-clearing RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_pkg;

    localparam int c_data_w_def = 16;
    localparam int c_depth_def  = 10;
    localparam int c_addr_w_def = 6;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } clr_state_t;

    // Bits needed to index a DEPTH-entry array (never less than one).
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_clr_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ram_clr_seq
//  Description : Clear sequencer; sweeps zeros through every word after reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_clr_seq
    import ram_pkg::*;
#(
    parameter int DEPTH  = c_depth_def,
    parameter int ADDR_W = c_addr_w_def
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          o_busy,
    output logic                          o_clr_we,
    output logic [idx_width(DEPTH)-1:0]   o_clr_idx
);

    localparam int                c_idx_w = idx_width(DEPTH);
    localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(DEPTH - 1);

    clr_state_t        r_state;
    clr_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // The pointer parks on the last word rather than wrapping.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        o_clr_we    = 1'b0;
        case (r_state)
            CLEAR: begin
                o_clr_we = ~rst;
                if (r_ptr == c_last) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_ptr_nxt = r_ptr + 1'b1;
                end
            end
            default: begin
                w_state_nxt = r_state;
            end
        endcase
    end

    assign o_busy    = (r_state == CLEAR);
    assign o_clr_idx = r_ptr[c_idx_w-1:0];

endmodule
`default_nettype wire

// File: rtl/ram_clr.sv
`default_nettype none
// ============================================================================
//  Module      : ram_clr
//  Description : Single-port-write / single-port-read RAM that zeroes itself
//                after reset, with range checking and optional read register.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_clr
    import ram_pkg::*;
#(
    parameter int DATA_W   = c_data_w_def,
    parameter int DEPTH    = c_depth_def,
    parameter int ADDR_W   = c_addr_w_def,
    parameter int READ_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] di,
    input  logic [ADDR_W-1:0] ra,
    // "do" is a reserved word, so the read data port is named dout.
    output logic [DATA_W-1:0] dout,
    output logic              busy,
    output logic              addr_err
);

    localparam int c_idx_w = idx_width(DEPTH);

    generate
        if (DEPTH > (2 ** ADDR_W)) begin : g_depth_chk
            $error("ram_clr: DEPTH does not fit in ADDR_W address bits");
        end
    endgenerate

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic               r_addr_err;
    logic               w_busy;
    logic               w_clr_we;
    logic [c_idx_w-1:0] w_clr_idx;
    logic               w_wa_in;
    logic               w_ra_in;
    logic               w_wr_ok;
    logic [c_idx_w-1:0] w_wa_idx;
    logic [c_idx_w-1:0] w_ra_idx;
    logic [DATA_W-1:0]  w_rd_mem;

    ram_clr_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_seq (
        .clk       (clk),
        .rst       (rst),
        .o_busy    (w_busy),
        .o_clr_we  (w_clr_we),
        .o_clr_idx (w_clr_idx)
    );

    assign w_wa_in  = (32'(wa) < 32'(DEPTH));
    assign w_ra_in  = (32'(ra) < 32'(DEPTH));
    assign w_wa_idx = wa[c_idx_w-1:0];
    assign w_ra_idx = ra[c_idx_w-1:0];
    // Writes during the sweep or a reset cycle are discarded outright.
    assign w_wr_ok  = we & ~w_busy & ~rst & w_wa_in;
    assign w_rd_mem = w_ra_in ? r_mem[w_ra_idx] : '0;

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_idx] <= '0;
        end else if (w_wr_ok) begin
            r_mem[w_wa_idx] <= di;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= ~w_busy & ((we & ~w_wa_in) | ~w_ra_in);
        end
    end

    generate
        if (READ_REG != 0) begin : g_rd_reg
            logic [DATA_W-1:0] r_dout;
            always_ff @(posedge clk) begin
                if (rst || w_busy) begin
                    r_dout <= '0;
                end else if (we && w_ra_in && (wa == ra)) begin
                    r_dout <= di;
                end else begin
                    r_dout <= w_rd_mem;
                end
            end
            assign dout = r_dout;
        end else begin : g_rd_comb
            assign dout = w_busy ? '0 : w_rd_mem;
        end
    endgenerate

    assign busy     = w_busy;
    assign addr_err = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_ram_clr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_clr
//  Description : Scoreboard bench for ram_clr, combinational and registered
//                read variants side by side on shared stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_clr;

    localparam int c_depth = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we  = 1'b0;
    logic [5:0]  wa  = '0;
    logic [15:0] di  = '0;
    logic [5:0]  ra  = '0;
    logic [15:0] dout_c, dout_r;
    logic        busy_c, busy_r, err_c, err_r;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model state
    logic [15:0] m_mem [c_depth];
    logic        m_busy = 1'b1;
    int          m_ptr  = 0;

    typedef struct {
        string       tag;
        logic [15:0] dreg;
        logic        err;
        int          due;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    ram_clr #(.DATA_W(16), .DEPTH(c_depth), .ADDR_W(6), .READ_REG(0)) u_comb (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .di(di), .ra(ra),
        .dout(dout_c), .busy(busy_c), .addr_err(err_c)
    );

    ram_clr #(.DATA_W(16), .DEPTH(c_depth), .ADDR_W(6), .READ_REG(1)) u_reg (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .di(di), .ra(ra),
        .dout(dout_r), .busy(busy_r), .addr_err(err_r)
    );

    // Registered outputs are checked one cycle after the stimulus that produced them.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            n_checks++;
            if (dout_r !== e.dreg) begin
                n_errors++;
                $display("FAIL %s reg_dout: got %h expected %h", e.tag, dout_r, e.dreg);
            end
            n_checks++;
            if (err_c !== e.err || err_r !== e.err) begin
                n_errors++;
                $display("FAIL %s addr_err: got %b/%b expected %b", e.tag, err_c, err_r, e.err);
            end
        end
    end

    task automatic drv(input logic r, input logic w, input logic [5:0] a,
                       input logic [15:0] d, input logic [5:0] rd);
        rst = r; we = w; wa = a; di = d; ra = rd;
        #1;
    endtask

    task automatic tick(input string tag);
        exp_t e;
        e.tag = tag;
        e.due = cyc + 1;
        if (rst || m_busy) begin
            e.dreg = '0;
            e.err  = 1'b0;
        end else begin
            if (we && wa == ra && ra < c_depth) e.dreg = di;
            else if (ra < c_depth)              e.dreg = m_mem[ra];
            else                                e.dreg = '0;
            e.err = (we && wa >= c_depth) || (ra >= c_depth);
        end
        q.push_back(e);
        @(posedge clk);
        if (rst) begin
            m_busy = 1'b1;
            m_ptr  = 0;
        end else if (m_busy) begin
            m_mem[m_ptr] = '0;
            if (m_ptr == c_depth - 1) m_busy = 1'b0;
            else                      m_ptr++;
        end else if (we && wa < c_depth) begin
            m_mem[wa] = di;
        end
        cyc++;
        #1;
    endtask

    function automatic logic [15:0] exp_comb(input logic [5:0] rd);
        if (m_busy || rd >= c_depth) return '0;
        return m_mem[rd];
    endfunction

    task automatic test_reset();
        int n;
        drv(1, 0, 0, 0, 3);
        tick("rst_pwr");
        drv(0, 0, 0, 0, 3);
        n_checks++;
        if (busy_c !== 1'b1 || busy_r !== 1'b1 || dout_c !== 16'h0) begin
            n_errors++;
            $display("FAIL reset_state: busy %b/%b dout %h expected 1/1 0000", busy_c, busy_r, dout_c);
        end
        n = 0;
        while (busy_c === 1'b1 && n < 20) begin
            tick("pwr_clear");
            n++;
        end
        n_checks++;
        if (n != c_depth || busy_r !== 1'b0) begin
            n_errors++;
            $display("FAIL pwr_busy_len: got %0d cycles expected %0d", n, c_depth);
        end
        for (int a = 0; a < c_depth; a++) begin
            drv(0, 0, 0, 0, 6'(a));
            n_checks++;
            if (dout_c !== 16'h0) begin
                n_errors++;
                $display("FAIL zero_after_clear[%0d]: got %h expected 0000", a, dout_c);
            end
            tick("zero_rd");
        end
    endtask

    task automatic test_preload_clear();
        int n;
        drv(0, 1, 3, 16'hBEEF, 3);
        tick("preload");
        drv(0, 0, 0, 0, 3);
        n_checks++;
        if (dout_c !== 16'hBEEF) begin
            n_errors++;
            $display("FAIL preload_rd: got %h expected beef", dout_c);
        end
        tick("preload_rd");
        drv(1, 0, 0, 0, 3);
        tick("rst_pulse");
        drv(0, 0, 0, 0, 3);
        n = 0;
        while (busy_c === 1'b1 && n < 20) begin
            tick("clear");
            n++;
        end
        n_checks++;
        if (n != c_depth) begin
            n_errors++;
            $display("FAIL clear_busy_len: got %0d cycles expected %0d", n, c_depth);
        end
        n_checks++;
        if (dout_c !== 16'h0) begin
            n_errors++;
            $display("FAIL cleared_rd3: got %h expected 0000", dout_c);
        end
        tick("cleared_rd3");
    endtask

    task automatic test_busy_write_drop();
        int n;
        drv(1, 0, 0, 0, 2);
        tick("rst_drop");
        n = 0;
        while (busy_c === 1'b1 && n < 20) begin
            drv(0, 1, (n == 3) ? 6'd12 : 6'd2, 16'h1234, 2);
            n_checks++;
            if (err_c !== 1'b0 || err_r !== 1'b0) begin
                n_errors++;
                $display("FAIL busy_no_err: got %b/%b expected 0", err_c, err_r);
            end
            tick("busy_wr");
            n++;
        end
        n_checks++;
        if (n != c_depth) begin
            n_errors++;
            $display("FAIL drop_busy_len: got %0d cycles expected %0d", n, c_depth);
        end
        drv(0, 0, 0, 0, 2);
        n_checks++;
        if (dout_c !== 16'h0) begin
            n_errors++;
            $display("FAIL dropped_wr: got %h expected 0000", dout_c);
        end
        tick("dropped_rd");
    endtask

    task automatic test_range_err();
        drv(0, 1, 12, 16'hFFFF, 15);
        n_checks++;
        if (dout_c !== 16'h0) begin
            n_errors++;
            $display("FAIL oob_rd: got %h expected 0000", dout_c);
        end
        tick("oob");
        drv(0, 0, 0, 0, 0);
        n_checks++;
        if (err_c !== 1'b1 || err_r !== 1'b1) begin
            n_errors++;
            $display("FAIL err_pulse: got %b/%b expected 1", err_c, err_r);
        end
        tick("oob_after");
        n_checks++;
        if (err_c !== 1'b0 || err_r !== 1'b0) begin
            n_errors++;
            $display("FAIL err_one_cycle: got %b/%b expected 0", err_c, err_r);
        end
        // 17 shares its low index bits with word 1; it must not alias.
        drv(0, 1, 17, 16'h7777, 1);
        tick("oob_alias");
        drv(0, 0, 0, 0, 1);
        n_checks++;
        if (dout_c !== 16'h0) begin
            n_errors++;
            $display("FAIL oob_alias: got %h expected 0000", dout_c);
        end
        tick("alias_rd");
    endtask

    task automatic test_bypass();
        drv(0, 1, 5, 16'hA5A5, 5);
        n_checks++;
        if (dout_c !== 16'h0) begin
            n_errors++;
            $display("FAIL comb_old_5: got %h expected 0000", dout_c);
        end
        tick("bypass");
        n_checks++;
        if (dout_r !== 16'hA5A5) begin
            n_errors++;
            $display("FAIL reg_bypass: got %h expected a5a5", dout_r);
        end
    endtask

    task automatic test_rbw();
        drv(0, 1, 4, 16'h0001, 0);
        tick("rbw_pre");
        drv(0, 1, 4, 16'h0002, 4);
        n_checks++;
        if (dout_c !== 16'h0001) begin
            n_errors++;
            $display("FAIL rbw_before: got %h expected 0001", dout_c);
        end
        tick("rbw_wr");
        drv(0, 0, 0, 0, 4);
        n_checks++;
        if (dout_c !== 16'h0002) begin
            n_errors++;
            $display("FAIL rbw_after: got %h expected 0002", dout_c);
        end
        tick("rbw_rd");
    endtask

    task automatic test_back_to_back();
        logic [5:0]  a, rd;
        logic [15:0] d;
        logic        w;
        for (int i = 0; i < 40; i++) begin
            w  = 1'($urandom_range(0, 1));
            a  = 6'($urandom_range(0, 11));
            d  = 16'($urandom);
            rd = (i % 3 == 0) ? a : 6'($urandom_range(0, 11));
            drv(0, w, a, d, rd);
            n_checks++;
            if (dout_c !== exp_comb(rd)) begin
                n_errors++;
                $display("FAIL b2b_comb[%0d]: got %h expected %h", i, dout_c, exp_comb(rd));
            end
            tick("b2b");
        end
    endtask

    task automatic test_mid_clear_reset();
        int n;
        for (int a = 0; a < c_depth; a++) begin
            drv(0, 1, 6'(a), 16'h1000 + 16'(a), 0);
            tick("fill");
        end
        drv(1, 0, 0, 0, 7);
        tick("rst_mid");
        drv(0, 0, 0, 0, 7);
        for (int i = 0; i < 6; i++) tick("part_clear");
        n_checks++;
        if (busy_c !== 1'b1 || dout_c !== 16'h0) begin
            n_errors++;
            $display("FAIL mid_busy: busy %b dout %h expected 1 0000", busy_c, dout_c);
        end
        drv(1, 0, 0, 0, 7);
        tick("rst_restart");
        drv(0, 0, 0, 0, 7);
        n = 0;
        while (busy_c === 1'b1 && n < 20) begin
            tick("restart_clear");
            n++;
        end
        n_checks++;
        if (n != c_depth) begin
            n_errors++;
            $display("FAIL restart_busy_len: got %0d cycles expected %0d", n, c_depth);
        end
        for (int a = 0; a < c_depth; a++) begin
            drv(0, 0, 0, 0, 6'(a));
            n_checks++;
            if (dout_c !== 16'h0) begin
                n_errors++;
                $display("FAIL restart_zero[%0d]: got %h expected 0000", a, dout_c);
            end
            tick("restart_rd");
        end
    endtask

    initial begin
        test_reset();
        test_preload_clear();
        test_busy_write_drop();
        test_range_err();
        test_bypass();
        test_rbw();
        test_back_to_back();
        test_mid_clear_reset();
        drv(0, 0, 0, 0, 0);
        tick("drain");
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
